// File: rtl/ic_write_buffer_if.sv
// Push/pull and head-entry bundle between the IC register front end, the
// write buffer and the downstream dispatcher.
interface ic_write_buffer_if #(
    parameter int K = 10,
    parameter int N = 32,
    parameter int D = 8
);
    localparam int LOG2_K = $clog2(K);
    localparam int LOG2_D = $clog2(D);

    logic              Push;
    logic [LOG2_K-1:0] PushAddr;
    logic [N-1:0]      PushVal;
    logic              PushWrite;
    logic              PullEn;
    logic [LOG2_K-1:0] AddrBuffer;
    logic [N-1:0]      ValBuffer;
    logic              WriteOp;
    logic              IsEmpty;
    logic              IsFull;
    logic [LOG2_D:0]   Count;
    logic              Start;
    logic              Overflow;
    logic              Underflow;

    modport master (
        output Push, PushAddr, PushVal, PushWrite, PullEn,
        input  AddrBuffer, ValBuffer, WriteOp, IsEmpty, IsFull, Count,
               Start, Overflow, Underflow
    );

    modport slave (
        input  Push, PushAddr, PushVal, PushWrite, PullEn,
        output AddrBuffer, ValBuffer, WriteOp, IsEmpty, IsFull, Count,
               Start, Overflow, Underflow
    );
endinterface

// File: rtl/ic_write_buffer.sv
// First-word-fall-through queue of pending IC register writes; the head entry
// is presented combinationally and Start pulses when work first appears.
module ic_write_buffer #(
    parameter int K = 10,
    parameter int N = 32,
    parameter int D = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Pwr_off,
    ic_write_buffer_if.slave   bus
);
    localparam int LOG2_K = $clog2(K);
    localparam int LOG2_D = $clog2(D);
    localparam int CNT_W  = LOG2_D + 1;
    localparam int ENT_W  = 1 + LOG2_K + N;

    typedef enum logic {EMPTY, ACTIVE} state_t;

    logic [ENT_W-1:0]  mem [D];
    logic [LOG2_D-1:0] wp_reg, rp_reg;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    state_t            state_reg, state_next;
    logic              start_reg, start_next;
    logic              ovf_reg, unf_reg;
    logic              run, is_empty, is_full, pull_acc, push_acc;
    logic [ENT_W-1:0]  head;

    // Power-off behaves exactly like reset, so both simply stop normal operation.
    assign run      = Rst && !Pwr_off;
    assign is_empty = (cnt_reg == '0);
    assign is_full  = (cnt_reg == CNT_W'(D));
    assign pull_acc = run && bus.PullEn && !is_empty;
    assign push_acc = run && bus.Push && (!is_full || pull_acc);

    always_comb begin
        cnt_next = cnt_reg;
        case ({push_acc, pull_acc})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    // Start only fires leaving EMPTY; a refill in the same cycle as the last pull keeps ACTIVE.
    always_comb begin
        state_next = state_reg;
        start_next = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (push_acc) begin
                    state_next = ACTIVE;
                    start_next = 1'b1;
                end
            end
            ACTIVE: begin
                if (pull_acc && !push_acc && cnt_reg == CNT_W'(1))
                    state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst || Pwr_off) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            cnt_reg   <= '0;
            state_reg <= EMPTY;
            start_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            if (push_acc) wp_reg <= wp_reg + 1'b1;
            if (pull_acc) rp_reg <= rp_reg + 1'b1;
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
            start_reg <= start_next;
            if (bus.Push && !push_acc) ovf_reg <= 1'b1;
            if (bus.PullEn && is_empty) unf_reg <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_acc)
            mem[wp_reg] <= {bus.PushWrite, bus.PushAddr, bus.PushVal};
    end

    // Stale storage is never visible: the head is masked while empty.
    assign head           = is_empty ? '0 : mem[rp_reg];
    assign bus.WriteOp    = head[ENT_W-1];
    assign bus.AddrBuffer = head[N +: LOG2_K];
    assign bus.ValBuffer  = head[N-1:0];
    assign bus.IsEmpty    = is_empty;
    assign bus.IsFull     = is_full;
    assign bus.Count      = cnt_reg;
    assign bus.Start      = start_reg;
    assign bus.Overflow   = ovf_reg;
    assign bus.Underflow  = unf_reg;
endmodule

// File: tb/tb_ic_write_buffer.sv
// Scoreboard bench: the driver predicts the post-edge outputs from a queue model
// and a separate monitor compares them against the buffer every cycle.
module tb_ic_write_buffer;
    localparam int K = 10;
    localparam int N = 32;
    localparam int D = 8;

    typedef struct {
        bit        w;
        bit [3:0]  a;
        bit [31:0] v;
    } entry_t;

    typedef struct {
        bit [3:0]  addr;
        bit [31:0] val;
        bit        wr;
        bit        empty;
        bit        full;
        int        count;
        bit        start;
        bit        ovf;
        bit        unf;
    } snap_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic Pwr_off = 1'b0;

    ic_write_buffer_if #(.K(K), .N(N), .D(D)) bus ();

    ic_write_buffer #(.K(K), .N(N), .D(D)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Pwr_off (Pwr_off),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    entry_t m_q[$];
    bit     m_ovf = 0;
    bit     m_unf = 0;
    snap_t  chk_q[$];
    int     n_checks = 0;
    int     n_fail = 0;

    task automatic check(input string name, input int cyc, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic cycle(input bit rst_n, input bit pwr, input bit push, input bit [3:0] a,
                         input bit [31:0] v, input bit w, input bit pull);
        snap_t  s;
        entry_t e;
        bit     pull_ok, push_ok, was_empty, st;
        @(negedge Clk);
        Rst = rst_n;
        Pwr_off = pwr;
        bus.Push = push;
        bus.PushAddr = a;
        bus.PushVal = v;
        bus.PushWrite = w;
        bus.PullEn = pull;
        st = 0;
        if (!rst_n || pwr) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            was_empty = (m_q.size() == 0);
            pull_ok = pull && !was_empty;
            push_ok = push && (m_q.size() < D || pull_ok);
            if (pull && was_empty) m_unf = 1;
            if (push && !push_ok) m_ovf = 1;
            if (pull_ok) void'(m_q.pop_front());
            if (push_ok) begin
                e.w = w; e.a = a; e.v = v;
                m_q.push_back(e);
            end
            st = was_empty && push_ok;
        end
        s.addr  = (m_q.size() > 0) ? m_q[0].a : 4'd0;
        s.val   = (m_q.size() > 0) ? m_q[0].v : 32'd0;
        s.wr    = (m_q.size() > 0) ? m_q[0].w : 1'b0;
        s.empty = (m_q.size() == 0);
        s.full  = (m_q.size() == D);
        s.count = m_q.size();
        s.start = st;
        s.ovf   = m_ovf;
        s.unf   = m_unf;
        chk_q.push_back(s);
    endtask

    task automatic idle();
        cycle(1, 0, 0, 4'd0, 32'd0, 0, 0);
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest prediction.
    int mon_cyc = 0;
    initial begin
        snap_t s;
        forever begin
            @(posedge Clk);
            #1;
            if (chk_q.size() > 0) begin
                s = chk_q.pop_front();
                mon_cyc++;
                check("AddrBuffer", mon_cyc, bus.AddrBuffer, s.addr);
                check("ValBuffer",  mon_cyc, bus.ValBuffer,  s.val);
                check("WriteOp",    mon_cyc, bus.WriteOp,    s.wr);
                check("IsEmpty",    mon_cyc, bus.IsEmpty,    s.empty);
                check("IsFull",     mon_cyc, bus.IsFull,     s.full);
                check("Count",      mon_cyc, bus.Count,      s.count);
                check("Start",      mon_cyc, bus.Start,      s.start);
                check("Overflow",   mon_cyc, bus.Overflow,   s.ovf);
                check("Underflow",  mon_cyc, bus.Underflow,  s.unf);
                $display("cycle %0d: count=%0d head=%0h/%0h/%0d start=%0d ovf=%0d unf=%0d",
                         mon_cyc, bus.Count, bus.AddrBuffer, bus.ValBuffer, bus.WriteOp,
                         bus.Start, bus.Overflow, bus.Underflow);
            end
        end
    end

    initial begin
        int wait_cnt;
        bus.Push = 0; bus.PushAddr = '0; bus.PushVal = '0; bus.PushWrite = 0; bus.PullEn = 0;

        // Reset, then a single write into the empty buffer and a second one.
        cycle(0, 0, 0, 4'd0, 32'd0, 0, 0);
        cycle(0, 0, 0, 4'd0, 32'd0, 0, 0);
        idle();
        cycle(1, 0, 1, 4'd3, 32'hDEAD_BEEF, 1, 0);
        idle();
        cycle(1, 0, 1, 4'd2, 32'h0000_1234, 0, 0);
        idle();
        cycle(1, 0, 0, 4'd0, 32'd0, 0, 1);
        cycle(1, 0, 0, 4'd0, 32'd0, 0, 1);
        idle();

        // Fill, overflow, drain.
        for (int i = 0; i < 8; i++) cycle(1, 0, 1, 4'(i), 32'(i), i[0], 0);
        cycle(1, 0, 1, 4'd9, 32'h99, 1, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 4'd0, 32'd0, 0, 1);
        idle();

        // Reset clears Overflow, then push+pull together while full.
        cycle(0, 0, 0, 4'd0, 32'd0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 1, 4'(i), 32'(i + 16), 0, 0);
        cycle(1, 0, 1, 4'd5, 32'hA5, 1, 1);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 4'd0, 32'd0, 0, 1);

        // Pull on empty with a simultaneous push, then pull with refill.
        cycle(1, 0, 1, 4'd1, 32'h11, 1, 1);
        cycle(1, 0, 1, 4'd2, 32'h22, 0, 1);
        idle();
        cycle(1, 0, 0, 4'd0, 32'd0, 0, 1);

        // Power-off and reset mid-operation, with a push during the reset cycle.
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 4'(i), 32'(i + 40), 1, 0);
        cycle(1, 1, 1, 4'd7, 32'h77, 1, 0);
        idle();
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 4'(i), 32'(i + 50), 0, 0);
        cycle(0, 0, 1, 4'd8, 32'h88, 1, 0);
        idle();

        // Randomized traffic with occasional power-off / reset.
        for (int i = 0; i < 400; i++) begin
            bit rn, pw;
            rn = ($urandom_range(127) != 0);
            pw = ($urandom_range(63) == 0);
            cycle(rn, pw, ($urandom_range(99) < 55), 4'($urandom_range(K - 1)), $urandom,
                  1'($urandom), ($urandom_range(99) < 45));
        end
        idle();

        wait_cnt = 0;
        while (chk_q.size() > 0 && wait_cnt < 20) begin
            @(posedge Clk);
            wait_cnt++;
        end
        #2;
        if (chk_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", chk_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ic_write_buffer.md
# ic_write_buffer

First-word-fall-through FIFO that queues pending interrupt-controller register writes and presents them, head entry first, to the downstream dispatcher. Each entry is a register index, a data word and a write-operation flag. The dispatcher consumes the head with a one-cycle `PullEn` pulse. The buffer also raises `Start` when work becomes available.

## Interface
Parameters:
- `K`, 10, number of IC register wrappers; index width `LOG2_K = $clog2(K)`
- `N`, 32, data word width
- `D`, 8, FIFO depth in entries; power of two, `D >= 2`; `LOG2_D = $clog2(D)`

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge
- `Rst`  in  1  synchronous, active-low reset
- `Pwr_off`  in  1  synchronous clear while high; same effect as reset
- `Push`  in  1  enqueue request for the current cycle
- `PushAddr`  in  `LOG2_K`  register index to enqueue
- `PushVal`  in  `N`  data word to enqueue
- `PushWrite`  in  1  write-operation flag to enqueue
- `PullEn`  in  1  dequeue the head entry; driven by the dispatcher
- `AddrBuffer`  out  `LOG2_K`  head register index
- `ValBuffer`  out  `N`  head data word
- `WriteOp`  out  1  head write flag
- `IsEmpty`  out  1  FIFO holds no entries
- `IsFull`  out  1  FIFO holds `D` entries
- `Count`  out  `LOG2_D+1`  current occupancy, 0..D
- `Start`  out  1  one-cycle pulse: buffer went from empty to non-empty
- `Overflow`  out  1  sticky: a push was dropped
- `Underflow`  out  1  sticky: a pull arrived while empty

## Operation
Storage and pointers:
- Storage: `D` entries of `{PushWrite, PushAddr, PushVal}`.
- Pointers: write pointer `wp` and read pointer `rp`, `LOG2_D` bits each, wrapping modulo `D`.
- Occupancy register `cnt`, width `LOG2_D+1`, drives `Count`.

Push, pull and flags:
- Push accepted when `Push` && (`cnt < D` || pull accepted in the same cycle). On accept: write entry at `wp`, then `wp <= wp+1`.
- Pull accepted when `PullEn` && `cnt != 0`. On accept: `rp <= rp+1`.
- `cnt`: +1 on push only, −1 on pull only, unchanged when both or neither are accepted.
- `Push` while full without an accepted pull: entry dropped, no state change except `Overflow <= 1`.
- `PullEn` while empty: ignored, `Underflow <= 1`. A simultaneous push into the empty FIFO is still accepted and is not popped in that cycle.
- `Overflow` and `Underflow` clear only on reset or `Pwr_off`.

Head outputs and status:
- Head outputs are combinational reads of entry `rp`. They are forced to all-zero when `cnt == 0`.
- `IsEmpty = (cnt == 0)`, `IsFull = (cnt == D)`; both are decoded combinationally from `cnt`.
- `Start` is registered: `Start <= (cnt == 0) && push accepted`. It is high for exactly one cycle after the first entry lands. It does not pulse while already non-empty.

Small state machine (for the `Start` generation only):
- `EMPTY` -> `ACTIVE` on an accepted push; `Start` asserted on that transition.
- `ACTIVE` -> `EMPTY` when the last entry is pulled with no simultaneous push.
- `ACTIVE` stays `ACTIVE` when the last entry is pulled and a push is accepted in the same cycle; no new `Start`.

Reset and power-off:
- Priority: `Rst == 0` > `Pwr_off == 1` > normal operation.
- Either condition sets `wp = rp = cnt = 0`, FSM = `EMPTY`, and clears `Start`, `Overflow` and `Underflow`.
- Storage contents are don't-care after reset and are never observable, because head outputs are masked while empty.

## Timing
Output values during and after reset:
- `IsEmpty = 1`, `IsFull = 0`, `Count = 0`, `Start = 0`, `Overflow = 0`, `Underflow = 0`.
- `AddrBuffer`, `ValBuffer` and `WriteOp` are all 0.

Latency:
- Push to visibility at the head (empty FIFO): 1 cycle. The entry sampled at edge t appears on `ValBuffer`/`AddrBuffer`/`WriteOp` and `IsEmpty = 0` after edge t. `Start` is high in that same following cycle.
- Pull: head advances at the edge that samples `PullEn`. The next entry, or zero if the FIFO is now empty, is visible right after that edge.

Throughput and pulse rules:
- One push and one pull per cycle, sustained, at any occupancy including full.
- `PullEn` is a one-cycle pulse per entry. A level held for n cycles pops min(n, occupancy) entries.

Reset mid-operation:
- Entries in flight are discarded.
- A `Push` in the reset cycle is ignored.

## Test plan
- Reset with `Rst = 0` for 2 cycles, then release -> `IsEmpty = 1`, `Count = 0`, all head outputs 0, no `Start` pulse.
- Push `{1, 3, 32'hDEAD_BEEF}` into the empty FIFO -> next cycle `AddrBuffer = 3`, `ValBuffer = 32'hDEADBEEF`, `WriteOp = 1`, `Start = 1` for exactly one cycle; a second push produces no `Start`.
- Fill with 8 pushes (values 0..7, addresses 0..7), then push 32'h99 -> `IsFull = 1`, `Count = 8`, `Overflow = 1`. Then pull 8 times -> values 0..7 in order, final `IsEmpty = 1`, entry 32'h99 never seen.
- At full, assert `Push` (value 32'hA5) and `PullEn` together -> `Count` stays 8, `Overflow` stays 0, 32'hA5 emerges as the 8th pull afterwards; checks pointer wrap.
- On the empty FIFO, assert `PullEn` with `Push` of 32'h11 in the same cycle -> `Underflow = 1`, `Count = 1`, head = 32'h11. Pull it with a simultaneous push of 32'h22 -> `Count = 1`, head = 32'h22, no second `Start`.
- With 5 entries queued, assert `Pwr_off` for 1 cycle, then separately `Rst = 0` with `Push` high -> `Count = 0`, `IsEmpty = 1`, head outputs 0, sticky flags cleared, the pushed entry absent.
